// File: rtl/conv_pkg.sv
// Shared types and widths for the 3x3 convolution window generator.
package conv_pkg;

  localparam int PIX_W = 4;
  localparam int WIN_W = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } conv_state_e;

endpackage

// File: rtl/line_buffer.sv
// Pixel-wide shift register of DEPTH stages; shifts only when en is high.
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             en,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  // Contents are never reset: stale data is masked by the row/col gating upstream.
  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window.sv
// Raster-order 3x3 window generator feeding the convolution datapath.
// Optional feature: define CONV_WINDOW_COUNT_EN to add the win_count output.
module conv_window
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             pixel_valid,
  input  logic [PIX_W-1:0] pixel_in,
  output logic [WIN_W-1:0] sample_out,
  output logic             conv_en,
  output logic             frame_done,
`ifdef CONV_WINDOW_COUNT_EN
  output logic [11:0]      win_count,
`endif
  output conv_state_e      state_dbg
);

  // Handshake: a pixel is accepted on a rising edge where pixel_valid=1 and the
  // FSM is in FILL or ACTIVE with no frame_start; there is no back-pressure.

  localparam logic [5:0] COL_LAST = 6'(IMG_W - 1);
  localparam logic [5:0] ROW_LAST = 6'(IMG_H - 1);

  conv_state_e      state, state_next;
  logic [5:0]       col, row;
  logic [WIN_W-1:0] win_q, win_next;
  logic [PIX_W-1:0] lb0_out, lb1_out;
  logic             accept, emit, last_pix;

  assign accept   = pixel_valid && !frame_start && (state == FILL || state == ACTIVE);
  assign emit     = accept && (row >= 6'd2) && (col >= 6'd2);
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);
  assign state_dbg = state;

  // Shift every window row left by one column; the new right column is
  // {two rows up, one row up, incoming pixel}.
  assign win_next = {pixel_in, win_q[35:28], lb0_out, win_q[23:16], lb1_out, win_q[11:4]};

  line_buffer #(.DEPTH(IMG_W - 1)) u_lb0 (
    .clk  (clk),
    .en   (accept),
    .din  (win_q[35:32]),
    .dout (lb0_out)
  );

  line_buffer #(.DEPTH(IMG_W - 1)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (win_q[23:20]),
    .dout (lb1_out)
  );

  always_comb begin
    state_next = state;
    if (frame_start) begin
      state_next = FILL;
    end else begin
      case (state)
        IDLE:   state_next = IDLE;
        FILL: begin
          if (accept && last_pix)  state_next = DONE;
          else if (emit)           state_next = ACTIVE;
        end
        ACTIVE: if (accept && last_pix) state_next = DONE;
        DONE:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      sample_out <= '0;
      conv_en    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      conv_en    <= emit;
      frame_done <= (state == DONE);
      if (emit) sample_out <= win_next;
      if (frame_start) begin
        col <= '0;
        row <= '0;
      end else if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? 6'd0 : row + 6'd1;
        end else begin
          col <= col + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) win_q <= win_next;
  end

`ifdef CONV_WINDOW_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst || frame_start) begin
      win_count <= '0;
    end else if (emit && win_count != 12'hFFF) begin
      win_count <= win_count + 12'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_window.sv
// Directed bench for conv_window on a 4x4 image (plus an 8x8 instance when
// CONV_WINDOW_COUNT_EN is defined).
module tb_conv_window;
  import conv_pkg::*;

  typedef struct {
    int               gap;
    logic [3:0]       base;
    bit               cst;
    int               exp_win;
    int               exp_spacing;
    logic [WIN_W-1:0] exp_first;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             frame_start;
  logic             pixel_valid;
  logic [3:0]       pixel_in;
  logic [WIN_W-1:0] sample_out;
  logic             conv_en;
  logic             frame_done;
  conv_state_e      state_dbg;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_win;
  int last_win_cyc;
  int win_cyc [2];
  bit got_done;
  logic [WIN_W-1:0] first_win;
  logic [WIN_W-1:0] exp_q [$];
  logic [3:0] frame_pix [16];
  vec_t tbl [3];

`ifdef CONV_WINDOW_COUNT_EN
  logic [11:0]      win_count, win_count8;
  logic [WIN_W-1:0] sample_out8;
  logic             conv_en8, frame_done8;
  conv_state_e      state_dbg8;
  bit               got_done8;
`endif

  conv_window #(.IMG_W(4), .IMG_H(4)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .sample_out  (sample_out),
    .conv_en     (conv_en),
    .frame_done  (frame_done),
`ifdef CONV_WINDOW_COUNT_EN
    .win_count   (win_count),
`endif
    .state_dbg   (state_dbg)
  );

`ifdef CONV_WINDOW_COUNT_EN
  conv_window #(.IMG_W(8), .IMG_H(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .sample_out  (sample_out8),
    .conv_en     (conv_en8),
    .frame_done  (frame_done8),
    .win_count   (win_count8),
    .state_dbg   (state_dbg8)
  );
`endif

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled on the next one.
  task automatic drive(input logic fs, input logic pv, input logic [3:0] pix);
    frame_start = fs;
    pixel_valid = pv;
    pixel_in    = pix;
    @(posedge clk);
    #1;
  endtask

  // Reference windows from the frame array: window ending at (r,c) covers rows r-2..r, cols c-2..c.
  task automatic load_windows();
    logic [WIN_W-1:0] w;
    for (int r = 2; r < 4; r++) begin
      for (int c = 2; c < 4; c++) begin
        w = '0;
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++)
            w[4*(3*rr+cc) +: 4] = frame_pix[(r-2+rr)*4 + (c-2+cc)];
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic start_frame_tracking();
    n_win = 0;
    got_done = 1'b0;
    win_cyc[0] = 0;
    win_cyc[1] = 0;
    first_win = '0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 12 && !got_done; t++) drive(1'b0, 1'b0, 4'h0);
    check("frame_done_seen", WIN_W'(got_done), WIN_W'(1));
  endtask

  task automatic run_frame(input vec_t v);
    for (int i = 0; i < 16; i++) frame_pix[i] = v.cst ? v.base : 4'(i + int'(v.base));
    load_windows();
    start_frame_tracking();
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, frame_pix[i]);
      for (int g = 0; g < v.gap; g++) drive(1'b0, 1'b0, 4'($urandom_range(15)));
    end
    wait_done();
    check("window_count", WIN_W'(n_win), WIN_W'(v.exp_win));
    check("first_window", first_win, v.exp_first);
    check("window_spacing", WIN_W'(win_cyc[1] - win_cyc[0]), WIN_W'(v.exp_spacing));
    check("exp_q_drained", WIN_W'(exp_q.size()), '0);
    check("state_idle_after_frame", WIN_W'(state_dbg), WIN_W'(IDLE));
  endtask

  // Scoreboard: every conv_en pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (conv_en) begin
      if (n_win < 2) win_cyc[n_win] = cyc;
      if (n_win == 0) first_win = sample_out;
      n_win++;
      last_win_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_window: got %h, required no window", sample_out);
      end else begin
        check("window", sample_out, exp_q.pop_front());
      end
    end
    if (frame_done) begin
      got_done = 1'b1;
      check("done_after_last_win", WIN_W'(cyc - last_win_cyc), WIN_W'(1));
    end
  end

`ifdef CONV_WINDOW_COUNT_EN
  always @(negedge clk) begin
    if (frame_done8) begin
      got_done8 = 1'b1;
      check("win_count_at_done", WIN_W'(win_count8), WIN_W'(36));
    end
  end
`endif

  initial begin
    tbl[0] = '{0, 4'h0, 1'b0, 4, 1, 36'hA98654210};
    tbl[1] = '{1, 4'h0, 1'b0, 4, 2, 36'hA98654210};
    tbl[2] = '{0, 4'h3, 1'b0, 4, 1, 36'hDCB987543};
    n_win = 0;
    last_win_cyc = 0;
    got_done = 1'b0;
`ifdef CONV_WINDOW_COUNT_EN
    got_done8 = 1'b0;
`endif

    rst = 1'b1;
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    pixel_in = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_sample_out", sample_out, '0);
    check("reset_conv_en", WIN_W'(conv_en), '0);
    check("reset_frame_done", WIN_W'(frame_done), '0);
    check("reset_state", WIN_W'(state_dbg), WIN_W'(IDLE));

    // Table: back-to-back, every-other-cycle stall, offset pixel values
    for (int i = 0; i < 3; i++) run_frame(tbl[i]);

    // Reset mid-frame after pixel 9, then a frame of all-0xF pixels
    start_frame_tracking();
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 4'(i + 1));
    rst = 1'b1;
    drive(1'b1, 1'b1, 4'h3);
    rst = 1'b0;
    check("rst_mid_sample_out", sample_out, '0);
    check("rst_mid_conv_en", WIN_W'(conv_en), '0);
    check("rst_mid_frame_done", WIN_W'(frame_done), '0);
    check("rst_mid_state", WIN_W'(state_dbg), WIN_W'(IDLE));
    run_frame('{0, 4'hF, 1'b1, 4, 1, 36'hFFFFFFFFF});

    // frame_start reissued after 7 pixels; the pixel in that same cycle is dropped
    for (int i = 0; i < 16; i++) frame_pix[i] = 4'(i);
    load_windows();
    start_frame_tracking();
    drive(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 4'hC);
    drive(1'b1, 1'b1, 4'h7);
    for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, frame_pix[i]);
    wait_done();
    check("abort_window_count", WIN_W'(n_win), WIN_W'(4));
    check("abort_exp_q_drained", WIN_W'(exp_q.size()), '0);

    // pixel_valid in IDLE with no frame_start must be ignored
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 4'(i + 9));
      check("idle_state_held", WIN_W'(state_dbg), WIN_W'(IDLE));
      check("idle_conv_en_low", WIN_W'(conv_en), '0);
    end
    run_frame(tbl[0]);

`ifdef CONV_WINDOW_COUNT_EN
    // 64-pixel stream: the 4x4 instance frames the first 16, the 8x8 one all 64
    for (int i = 0; i < 16; i++) frame_pix[i] = 4'(i);
    load_windows();
    start_frame_tracking();
    got_done8 = 1'b0;
    drive(1'b1, 1'b0, 4'h0);
    check("win_count_cleared", WIN_W'(win_count8), '0);
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b1, 4'(i));
    for (int t = 0; t < 12 && !got_done8; t++) drive(1'b0, 1'b0, 4'h0);
    check("frame_done8_seen", WIN_W'(got_done8), WIN_W'(1));
    check("count_exp_q_drained", WIN_W'(exp_q.size()), '0);
`endif

    repeat (2) drive(1'b0, 1'b0, 4'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
